// File: rtl/font5x7_tone_sounder_if.sv
// font5x7_tone_sounder_if: note push channel (valid/ready with half-period and duration)
interface font5x7_tone_sounder_if #(
  parameter int C_HALF_W = 16,
  parameter int C_LEN_W  = 8
);
  logic                NOTE_VLD;
  logic                NOTE_RDY;
  logic [C_HALF_W-1:0] NOTE_HALFs;
  logic [C_LEN_W-1:0]  NOTE_LENs;
  modport master (output NOTE_VLD, NOTE_HALFs, NOTE_LENs, input NOTE_RDY);
  modport slave  (input NOTE_VLD, NOTE_HALFs, NOTE_LENs, output NOTE_RDY);
endinterface

// File: rtl/font5x7_tone_sounder.sv
// font5x7_tone_sounder: note FIFO plus square-wave sequencer timed by the pixel-clock enable
module font5x7_tone_sounder #(
  parameter int C_HALF_W     = 16,
  parameter int C_LEN_W      = 8,
  parameter int C_DUR_DIV    = 12273,
  parameter int C_FIFO_DEPTH = 4,
  localparam int AW = $clog2(C_FIFO_DEPTH),
  localparam int CW = AW + 1,
  localparam int DW = (C_DUR_DIV > 1) ? $clog2(C_DUR_DIV) : 1
) (
  input  logic                        CK_i,
  input  logic                        SRST_i,
  input  logic                        PX_CK_EE_i,
  input  logic                        STOP_i,
  font5x7_tone_sounder_if.slave       note,
  output logic                        SOUND_o,
  output logic                        BUSY_o,
  output logic [CW-1:0]               FIFO_CNTs_o
);
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} st_t;
  st_t                 st_q;
  logic [C_HALF_W-1:0] half_mem [C_FIFO_DEPTH];
  logic [C_LEN_W-1:0]  len_mem  [C_FIFO_DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [C_HALF_W-1:0] half_q, pcnt_q;
  logic [C_LEN_W-1:0]  dur_q;
  logic [DW-1:0]       dcnt_q;
  logic                sound_q, push, pop, p_wrap, d_wrap;
  assign note.NOTE_RDY = ~SRST_i & ~STOP_i & (cnt_q < CW'(C_FIFO_DEPTH));
  assign SOUND_o       = sound_q;
  assign BUSY_o        = (st_q != IDLE) | (cnt_q != '0);
  assign FIFO_CNTs_o   = cnt_q;
  // Handshake, occupancy and counter wrap decodes
  always_comb begin
    push   = note.NOTE_VLD & note.NOTE_RDY;
    pop    = st_q == LOAD;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
    p_wrap = pcnt_q == half_q - C_HALF_W'(1);
    d_wrap = dcnt_q == DW'(C_DUR_DIV - 1);
  end
  // Note storage, written only when a push handshake completes
  always_ff @(posedge CK_i)
    if (push) begin
      half_mem[wr_q] <= note.NOTE_HALFs;
      len_mem[wr_q]  <= note.NOTE_LENs;
    end
  // FIFO pointers and occupancy; STOP flushes like reset
  always_ff @(posedge CK_i)
    if (SRST_i | STOP_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + AW'(push);
      rd_q  <= rd_q + AW'(pop);
      cnt_q <= cnt_d;
    end
  // Sequencer: fetch a note, then tone and duration counters advance on enabled ticks
  always_ff @(posedge CK_i)
    if (SRST_i | STOP_i) begin
      st_q    <= IDLE;
      sound_q <= 1'b0;
      half_q  <= '0;
      dur_q   <= '0;
      pcnt_q  <= '0;
      dcnt_q  <= '0;
    end else
      case (st_q)
        IDLE: if (cnt_q != '0) st_q <= LOAD;
        LOAD: begin
          half_q  <= half_mem[rd_q];
          dur_q   <= len_mem[rd_q];
          pcnt_q  <= '0;
          dcnt_q  <= '0;
          sound_q <= 1'b0;
          st_q    <= (len_mem[rd_q] == '0) ? IDLE : PLAY;
        end
        PLAY: if (PX_CK_EE_i) begin
          pcnt_q <= p_wrap ? '0 : pcnt_q + C_HALF_W'(1);
          dcnt_q <= d_wrap ? '0 : dcnt_q + DW'(1);
          if (d_wrap) dur_q <= dur_q - C_LEN_W'(1);
          if (d_wrap && dur_q == C_LEN_W'(1)) begin
            sound_q <= 1'b0;
            st_q    <= IDLE;
          end else if (p_wrap && half_q != '0) sound_q <= ~sound_q;
        end
        default: st_q <= IDLE;
      endcase
endmodule

// File: tb/tb_font5x7_tone_sounder.sv
// tb_font5x7_tone_sounder: directed and random note streams scored against a tick-count model
module tb_font5x7_tone_sounder;
  localparam int DIV = 4;
  logic       clk = 0, rst = 1, stop = 0, ee = 1;
  logic       snd, busy;
  logic [2:0] cnt;
  int         errs = 0, nchk = 0, ee_mode = 0, cyc = 0;
  font5x7_tone_sounder_if #(.C_HALF_W(16), .C_LEN_W(8)) bus ();
  font5x7_tone_sounder #(.C_HALF_W(16), .C_LEN_W(8), .C_DUR_DIV(DIV), .C_FIFO_DEPTH(4)) dut (
    .CK_i(clk), .SRST_i(rst), .PX_CK_EE_i(ee), .STOP_i(stop), .note(bus),
    .SOUND_o(snd), .BUSY_o(busy), .FIFO_CNTs_o(cnt)
  );
  initial forever #5 clk = ~clk;
  typedef struct {int h; int l;} note_t;
  typedef struct {bit s; bit b; int c;} exp_t;
  note_t mq[$];
  exp_t  sb[$];
  // Reference: a queue of notes; the sounding note's level is derived from ticks elapsed
  initial begin
    int  ph, ch, cl, t, n0;
    bit  ms, acc;
    ph = 0; ms = 0; ch = 0; cl = 0; t = 0;
    forever begin
      @(posedge clk);
      n0  = mq.size();
      acc = bus.NOTE_VLD && !rst && !stop && n0 < 4;
      if (rst || stop) begin
        mq.delete();
        ph = 0;
        ms = 0;
      end else begin
        if (ph == 0) begin
          if (n0 != 0) ph = 1;
        end else if (ph == 1) begin
          ch = mq[0].h;
          cl = mq[0].l;
          mq.delete(0);
          t  = 0;
          ms = 0;
          ph = (cl == 0) ? 0 : 2;
        end else if (ee) begin
          t++;
          if (t == cl * DIV) begin
            ms = 0;
            ph = 0;
          end else ms = (ch == 0) ? 0 : ((t / ch) % 2 == 1);
        end
        if (acc) mq.push_back('{int'(bus.NOTE_HALFs), int'(bus.NOTE_LENs)});
      end
      sb.push_back('{ms, (ph != 0) || (mq.size() != 0), mq.size()});
    end
  end
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  // Monitor: every cycle the DUT outputs are compared with the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("sound", 32'(snd), 32'(e.s));
        check("busy", 32'(busy), 32'(e.b));
        check("cnt", 32'(cnt), 32'(e.c));
        check("rdy", 32'(bus.NOTE_RDY), 32'(!rst && !stop && e.c < 4));
      end
    end
  end
  initial begin
    bit [1:0] r;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      r  = 2'($urandom_range(0, 1));
      ee = (ee_mode == 0) ? 1'b1 : (ee_mode == 1) ? (cyc % 3 == 0) : r[0];
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic push(input int h, input int l);
    bit ok = 0;
    bus.NOTE_VLD   = 1;
    bus.NOTE_HALFs = 16'(h);
    bus.NOTE_LENs  = 8'(l);
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      ok = bus.NOTE_RDY;
      step();
    end
    bus.NOTE_VLD   = 0;
    bus.NOTE_HALFs = 16'($urandom);
    bus.NOTE_LENs  = 8'($urandom);
    if (!ok) begin
      nchk++;
      errs++;
      $display("FAIL push_timeout: got rdy=0 expected rdy=1 within 3000 cycles");
    end
  endtask
  task automatic wait_idle();
    bit ok = 0;
    for (int k = 0; k < 3000 && !ok; k++) begin
      @(negedge clk);
      ok = !busy;
      step();
    end
    if (!ok) begin
      nchk++;
      errs++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0 within 3000 cycles");
    end
  endtask
  initial begin
    bus.NOTE_VLD   = 0;
    bus.NOTE_HALFs = 0;
    bus.NOTE_LENs  = 0;
    step(3);
    rst = 0;
    step(2);
    push(2, 3);
    step(5);
    rst = 1;
    step(3);
    rst = 0;
    step(2);
    push(3, 2);
    wait_idle();
    ee_mode = 1;
    push(3, 2);
    wait_idle();
    ee_mode = 0;
    repeat (6) push(2, 1);
    wait_idle();
    push(0, 1);
    push(5, 0);
    push(1, 1);
    wait_idle();
    repeat (4) push(2, 3);
    step(3);
    stop = 1;
    bus.NOTE_VLD   = 1;
    bus.NOTE_HALFs = 16'd4;
    bus.NOTE_LENs  = 8'd2;
    step();
    stop = 0;
    bus.NOTE_VLD = 0;
    step(3);
    repeat (8) push(1, 1);
    wait_idle();
    ee_mode = 2;
    for (int i = 0; i < 40; i++) begin
      push(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 9) == 0) begin
        stop = 1;
        step();
        stop = 0;
      end
      step(int'($urandom_range(0, 3)));
    end
    wait_idle();
    step(3);
    $display("Result: errors=%0d of %0d checks", errs, nchk);
    $finish;
  end
endmodule
